// File: rtl/ec_cntl_pkg.sv
// Shared constants, types and helpers for the encoding-engine sequencer.
package ec_cntl_pkg;

   localparam int unsigned K_MAX     = 128;
   localparam int unsigned M_MAX     = 128;
   localparam int unsigned M_MIN     = 2;
   localparam int unsigned LINES_MAX = 65535;

   localparam int unsigned MREG_W    = $clog2(M_MAX + 1);
   localparam int unsigned LINE_W    = $clog2(LINES_MAX + 1);

   // Write path latency: one cycle bitmatrix read plus one cycle engine.
   localparam int unsigned BM_RD_LAT = 1;
   localparam int unsigned ENG_LAT   = 1;
   localparam int unsigned WR_DELAY  = BM_RD_LAT + ENG_LAT;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      COMPUTE,
      DRAIN
   } seq_state_t;

   // Slot carried down the write pipeline; valid must stay the MSB.
   typedef struct packed {
      logic              valid;
      logic [MREG_W-1:0] row;
   } wr_slot_t;

   // Bring a configured row count into the supported [M_MIN, M_MAX] range.
   function automatic logic [MREG_W-1:0] clamp_m(input logic [MREG_W-1:0] m);
      if (m < MREG_W'(M_MIN)) return MREG_W'(M_MIN);
      if (m > MREG_W'(M_MAX)) return MREG_W'(M_MAX);
      return m;
   endfunction

endpackage

// File: rtl/eng_seq_cntl_if.sv
// Control, FIFO, bitmatrix, engine and outbuf signals of the sequencer.
interface eng_seq_cntl_if;
   import ec_cntl_pkg::*;

   logic              start;
   logic [MREG_W-1:0] m_cfg;
   logic [LINE_W-1:0] num_lines;
   logic              inbuf_empty;
   logic              inbuf_rd_rq;
   logic              eng_load;
   logic              bm_rd_en;
   logic [MREG_W-1:0] bm_rd_addr;
   logic              eng_data_used;
   logic              outbuf_afull;
   logic              outbuf_wr_en;
   logic [MREG_W-1:0] outbuf_wr_row;
   logic              busy;
   logic              done;

   // Sequencer side.
   modport master (
      input  start, m_cfg, num_lines, inbuf_empty, outbuf_afull,
      output inbuf_rd_rq, eng_load, bm_rd_en, bm_rd_addr, eng_data_used,
             outbuf_wr_en, outbuf_wr_row, busy, done
   );

   // Surrounding controller, FIFO, memory, engine and outbuf.
   modport slave (
      output start, m_cfg, num_lines, inbuf_empty, outbuf_afull,
      input  inbuf_rd_rq, eng_load, bm_rd_en, bm_rd_addr, eng_data_used,
             outbuf_wr_en, outbuf_wr_row, busy, done
   );

endinterface

// File: rtl/ec_delay_line.sv
// Fixed-latency shift register with synchronous clear; MSB of each word is a valid flag.
module ec_delay_line #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             pend
);

   logic [WIDTH-1:0] stg [DEPTH];

   // Shift one stage per cycle; clear flushes every stage.
   always_ff @(posedge clk) begin
      if (clr) begin
         for (int unsigned i = 0; i < DEPTH; i++) stg[i] <= '0;
      end else begin
         stg[0] <= din;
         for (int unsigned i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
      end
   end

   assign dout = stg[DEPTH-1];

   // Valid words still upstream of the output stage.
   always_comb begin
      pend = 1'b0;
      for (int unsigned i = 0; i + 1 < DEPTH; i++) pend = pend | stg[i][WIDTH-1];
   end

endmodule

// File: rtl/eng_seq_cntl.sv
// Sequences the encoding engine over a job of N lines with M parity rows each.
module eng_seq_cntl
   import ec_cntl_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   eng_seq_cntl_if.master bus
);

   seq_state_t        state_q;
   logic [MREG_W-1:0] m_q;
   logic [MREG_W-1:0] row_q;
   logic [LINE_W-1:0] lines_q;
   logic              eng_load_q;
   logic              busy_q;
   logic              done_q;

   logic              pop;
   logic              issue;
   logic              last_row;
   logic              wr_pend;
   wr_slot_t          wr_in;
   wr_slot_t          wr_out;

   // Pop and issue react to FIFO empty / outbuf almost-full in the same cycle.
   assign pop      = (state_q == FETCH) && !bus.inbuf_empty;
   assign issue    = (state_q == COMPUTE) && !bus.outbuf_afull;
   assign last_row = (row_q == (m_q - MREG_W'(1)));

   assign bus.inbuf_rd_rq   = pop;
   assign bus.bm_rd_en      = issue;
   assign bus.bm_rd_addr    = issue ? row_q : '0;
   assign bus.eng_data_used = issue;
   assign bus.eng_load      = eng_load_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;

   // Job sequencing: line fetch, engine load, row issue, pipeline drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         m_q        <= '0;
         row_q      <= '0;
         lines_q    <= '0;
         eng_load_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         eng_load_q <= 1'b0;
         done_q     <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  m_q     <= clamp_m(bus.m_cfg);
                  lines_q <= bus.num_lines;
                  if (bus.num_lines == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     busy_q  <= 1'b1;
                     state_q <= FETCH;
                  end
               end
            end
            FETCH: begin
               if (pop) begin
                  eng_load_q <= 1'b1;
                  state_q    <= LOAD;
               end
            end
            LOAD: begin
               row_q   <= '0;
               state_q <= COMPUTE;
            end
            COMPUTE: begin
               if (issue) begin
                  if (last_row) begin
                     row_q   <= '0;
                     lines_q <= lines_q - LINE_W'(1);
                     state_q <= (lines_q == LINE_W'(1)) ? DRAIN : FETCH;
                  end else begin
                     row_q <= row_q + MREG_W'(1);
                  end
               end
            end
            DRAIN: begin
               // Once nothing is upstream of the output stage, the final write is leaving now.
               if (!wr_pend) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Issued rows travel to the outbuf write port through a non-stallable pipeline.
   always_comb begin
      wr_in.valid = issue;
      wr_in.row   = issue ? row_q : '0;
   end

   ec_delay_line #(
      .WIDTH ($bits(wr_slot_t)),
      .DEPTH (WR_DELAY)
   ) u_wr_dly (
      .clk  (clk),
      .clr  (rst),
      .din  (wr_in),
      .dout (wr_out),
      .pend (wr_pend)
   );

   assign bus.outbuf_wr_en  = wr_out.valid;
   assign bus.outbuf_wr_row = wr_out.row;

endmodule

// File: tb/tb_eng_seq_cntl.sv
// Randomized and directed bench for eng_seq_cntl with a queue-based reference model.
module tb_eng_seq_cntl;
   import ec_cntl_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   eng_seq_cntl_if bus();

   eng_seq_cntl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // Input background noise and directed overrides.
   int e_pct = 0;
   int a_pct = 0;
   bit force_e = 1'b0;
   bit force_a = 1'b0;

   // Reference model: job progress flags plus a time-stamped queue of pending writes.
   typedef struct { int t; int row; } wr_t;
   wr_t wq[$];
   bit  armed = 1'b0;
   int  mcyc  = 0;
   bit  m_busy, m_fetch, m_load, m_comp, m_drain, m_done;
   int  m_M, m_row, m_lines;

   // Observed per-job statistics.
   int t_start, t_done, n_rd, n_used, n_wr, n_done, last_addr;
   int rd_t[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, mcyc, act, exp);
      end
   endtask

   function automatic int clamp_rows(input int cfg);
      if (cfg < 2) return 2;
      if (cfg > 128) return 128;
      return cfg;
   endfunction

   // Per-cycle compare against the model, then advance the model across the next edge.
   always @(negedge clk) begin
      bit e_rd, e_iss, e_wr, o_fetch, o_load, o_drain, nd, nl;
      int e_wrrow;
      wr_t tmp;
      e_rd    = m_fetch && (bus.inbuf_empty === 1'b0);
      e_iss   = m_comp && (bus.outbuf_afull === 1'b0);
      e_wr    = (wq.size() > 0) && (wq[0].t == mcyc);
      e_wrrow = e_wr ? wq[0].row : 0;
      if (armed) begin
         chk("inbuf_rd_rq",   32'(bus.inbuf_rd_rq),   32'(e_rd));
         chk("eng_load",      32'(bus.eng_load),      32'(m_load));
         chk("bm_rd_en",      32'(bus.bm_rd_en),      32'(e_iss));
         chk("bm_rd_addr",    32'(bus.bm_rd_addr),    32'(e_iss ? m_row : 0));
         chk("eng_data_used", 32'(bus.eng_data_used), 32'(e_iss));
         chk("outbuf_wr_en",  32'(bus.outbuf_wr_en),  32'(e_wr));
         chk("outbuf_wr_row", 32'(bus.outbuf_wr_row), 32'(e_wrrow));
         chk("busy",          32'(bus.busy),          32'(m_busy));
         chk("done",          32'(bus.done),          32'(m_done));
         if (bus.start && !bus.busy) t_start = mcyc;
         if (bus.inbuf_rd_rq) begin n_rd++; rd_t.push_back(mcyc); end
         if (bus.eng_data_used) begin n_used++; last_addr = int'(bus.bm_rd_addr); end
         if (bus.outbuf_wr_en) n_wr++;
         if (bus.done) begin n_done++; t_done = mcyc; end
      end
      if (rst) begin
         m_busy = 0; m_fetch = 0; m_load = 0; m_comp = 0; m_drain = 0; m_done = 0;
         m_row = 0; m_lines = 0; m_M = 2;
         wq.delete();
         armed = 1'b1;
      end else begin
         o_fetch = m_fetch; o_load = m_load; o_drain = m_drain;
         nd = 0; nl = 0;
         if (e_wr) tmp = wq.pop_front();
         if (bus.start && !m_busy) begin
            m_M = clamp_rows(int'(bus.m_cfg));
            m_lines = int'(bus.num_lines);
            if (m_lines == 0) nd = 1;
            else begin m_busy = 1; m_fetch = 1; end
         end
         if (o_fetch && e_rd) begin m_fetch = 0; nl = 1; end
         if (o_load) begin m_comp = 1; m_row = 0; end
         if (e_iss) begin
            wq.push_back('{mcyc + 2, m_row});
            if (m_row == m_M - 1) begin
               m_row = 0; m_lines--; m_comp = 0;
               if (m_lines > 0) m_fetch = 1; else m_drain = 1;
            end else m_row++;
         end
         if (o_drain && wq.size() == 0) begin m_drain = 0; m_busy = 0; nd = 1; end
         m_done = nd; m_load = nl;
      end
      mcyc++;
   end

   // FIFO-empty and outbuf-almost-full drivers.
   initial begin
      bus.inbuf_empty  = 1'b0;
      bus.outbuf_afull = 1'b0;
      forever begin
         @(posedge clk); #1;
         bus.inbuf_empty  = force_e || ($urandom_range(99) < e_pct);
         bus.outbuf_afull = force_a || ($urandom_range(99) < a_pct);
      end
   end

   task automatic clear_stats();
      n_rd = 0; n_used = 0; n_wr = 0; n_done = 0; last_addr = -1;
      t_start = -1000; t_done = -1000;
      rd_t.delete();
   endtask

   task automatic do_start(input int m, input int l);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.m_cfg = MREG_W'(m); bus.num_lines = LINE_W'(l);
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string nm);
      int n = 0;
      while (1) begin
         @(negedge clk);
         if (bus.done) break;
         n++;
         if (n > budget) begin
            checks++; errors++;
            $display("FAIL %s: no done within %0d cycles", nm, budget);
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_issue(input int addr, input int budget, input string nm);
      int n = 0;
      while (1) begin
         @(negedge clk);
         if (bus.eng_data_used && int'(bus.bm_rd_addr) == addr) break;
         n++;
         if (n > budget) begin
            checks++; errors++;
            $display("FAIL %s: row %0d never issued", nm, addr);
            break;
         end
      end
   endtask

   initial begin
      int m, l;
      rst = 1'b1; bus.start = 1'b0; bus.m_cfg = '0; bus.num_lines = '0;
      clear_stats();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Basic job M=4, L=2.
      clear_stats();
      do_start(4, 2);
      wait_done(100, "basic");
      chk("basic_rd_count", 32'(rd_t.size()), 32'd2);
      if (rd_t.size() == 2) begin
         chk("basic_rd0_cycle", 32'(rd_t[0] - t_start), 32'd1);
         chk("basic_rd1_cycle", 32'(rd_t[1] - t_start), 32'd7);
      end
      chk("basic_used", 32'(n_used), 32'd8);
      chk("basic_writes", 32'(n_wr), 32'd8);
      chk("basic_done_count", 32'(n_done), 32'd1);
      chk("basic_done_cycle", 32'(t_done - t_start), 32'd15);

      // Backpressure: M=3, L=1, afull for 3 cycles after row 0.
      clear_stats();
      do_start(3, 1);
      wait_issue(0, 20, "stall");
      force_a = 1'b1;
      repeat (3) @(negedge clk);
      force_a = 1'b0;
      wait_done(100, "stall");
      chk("stall_used", 32'(n_used), 32'd3);
      chk("stall_writes", 32'(n_wr), 32'd3);
      chk("stall_done_cycle", 32'(t_done - t_start), 32'd11);

      // Empty FIFO for 5 cycles before line 2: M=2, L=2.
      clear_stats();
      do_start(2, 2);
      wait_issue(1, 20, "empty");
      force_e = 1'b1;
      repeat (5) @(negedge clk);
      force_e = 1'b0;
      wait_done(100, "empty");
      chk("empty_rd_count", 32'(rd_t.size()), 32'd2);
      if (rd_t.size() == 2) chk("empty_rd1_cycle", 32'(rd_t[1] - t_start), 32'd10);
      chk("empty_writes", 32'(n_wr), 32'd4);
      chk("empty_done_count", 32'(n_done), 32'd1);
      chk("empty_done_cycle", 32'(t_done - t_start), 32'd16);

      // m_cfg=0 runs as two rows.
      clear_stats();
      do_start(0, 2);
      wait_done(100, "mmin");
      chk("mmin_used", 32'(n_used), 32'd4);
      chk("mmin_writes", 32'(n_wr), 32'd4);

      // m_cfg=M_MAX.
      clear_stats();
      do_start(int'(M_MAX), 1);
      wait_done(400, "mmax");
      chk("mmax_used", 32'(n_used), 32'd128);
      chk("mmax_last_addr", 32'(last_addr), 32'd127);
      chk("mmax_writes", 32'(n_wr), 32'd128);
      chk("mmax_done_cycle", 32'(t_done - t_start), 32'd133);

      // Zero-line job.
      clear_stats();
      do_start(5, 0);
      wait_done(10, "zero");
      chk("zero_done_cycle", 32'(t_done - t_start), 32'd1);
      chk("zero_rd_count", 32'(n_rd), 32'd0);
      chk("zero_done_count", 32'(n_done), 32'd1);

      // Reset during row 2 of M=4, then a clean job.
      clear_stats();
      do_start(4, 2);
      wait_issue(1, 20, "reset");
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("reset_no_done", 32'(n_done), 32'd0);
      chk("reset_writes_cut", 32'(n_wr < 8), 32'd1);
      clear_stats();
      do_start(4, 1);
      wait_done(100, "after_reset");
      chk("after_reset_used", 32'(n_used), 32'd4);
      chk("after_reset_done", 32'(n_done), 32'd1);

      // start while busy is ignored.
      clear_stats();
      do_start(3, 2);
      repeat (2) @(posedge clk);
      #1 bus.start = 1'b1; bus.m_cfg = MREG_W'(5); bus.num_lines = LINE_W'(4);
      @(posedge clk); #1 bus.start = 1'b0;
      wait_done(200, "restart");
      chk("restart_writes", 32'(n_wr), 32'd6);
      chk("restart_rd_count", 32'(n_rd), 32'd2);
      chk("restart_done_count", 32'(n_done), 32'd1);

      // Randomized jobs with random empty/afull.
      e_pct = 25; a_pct = 25;
      for (int j = 0; j < 12; j++) begin
         m = $urandom_range(0, 10);
         l = $urandom_range(0, 3);
         clear_stats();
         do_start(m, l);
         wait_done(600, "rand");
         chk("rand_writes", 32'(n_wr), 32'(clamp_rows(m) * l));
         chk("rand_rd_count", 32'(n_rd), 32'(l));
         chk("rand_done_count", 32'(n_done), 32'd1);
      end
      e_pct = 0; a_pct = 0;
      repeat (4) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
